// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory arbiter: owner-state enum,
// default sizing and the aligned/in-bounds access check.
package dmem_pkg;

  typedef enum logic [1:0] {StIdle, StCore, StLoad, StLock} arb_state_e;

  localparam int unsigned MemBytesDefault = 64;
  localparam int unsigned LockMaxDefault  = 8;
  localparam int unsigned AddrWMax        = 64;
  localparam int unsigned AddrWExt        = AddrWMax + 1;

  // One extra bit on the end address so addr+8 wrapping past 2^64 reads as out of range.
  function automatic logic access_ok(input logic [AddrWMax-1:0] addr,
                                     input int unsigned         mem_bytes);
    logic [AddrWMax:0] end_addr;
    end_addr = {1'b0, addr} + AddrWExt'(8);
    return (addr[2:0] == 3'b000) && (end_addr <= AddrWExt'(mem_bytes));
  endfunction

endpackage

// File: rtl/dmem_rr_pick.sv
// Two-way grant picker: a lone requester wins, otherwise the loader keeps a
// bounded lock, otherwise the port not served last wins.
module dmem_rr_pick
  import dmem_pkg::*;
#(
  parameter int unsigned LOCK_MAX = LockMaxDefault
) (
  input  logic       c_req,
  input  logic       l_req,
  input  arb_state_e state,
  input  logic [3:0] lock_cnt,
  output logic       c_win,
  output logic       l_win
);

  always_comb begin
    c_win = 1'b0;
    l_win = 1'b0;
    if (c_req && l_req) begin
      if (state == StLock && 32'(lock_cnt) < LOCK_MAX) begin
        l_win = 1'b1;
      end else if (state == StCore) begin
        l_win = 1'b1;
      end else begin
        // Idle counts as "loader served last", so the core goes first.
        c_win = 1'b1;
      end
    end else begin
      c_win = c_req;
      l_win = l_req;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one 64-bit data memory between the core MEM stage and the loader:
// one access per cycle, combinational grant, registered one-cycle response.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W    = 64,
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned MEM_BYTES = MemBytesDefault,
  parameter int unsigned LOCK_MAX  = LockMaxDefault
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  output logic              c_err,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  input  logic              l_lock,
  output logic              l_gnt,
  output logic              l_rvalid,
  output logic [DATA_W-1:0] l_rdata,
  output logic              l_err,
  output logic              core_stall,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [DATA_W-1:0] Write_Data,
  output logic              MemWrite,
  output logic              MemRead,
  input  logic [DATA_W-1:0] Read_Data
);

  arb_state_e        state_q, state_d;
  logic [3:0]        lock_cnt_q, lock_cnt_d;
  logic              c_win, l_win, any_gnt;
  logic              sel_we, sel_ok;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata, rdata_d;
  logic              c_rvalid_q, c_err_q, l_rvalid_q, l_err_q;
  logic [DATA_W-1:0] c_rdata_q, l_rdata_q;

  dmem_rr_pick #(
    .LOCK_MAX(LOCK_MAX)
  ) u_pick (
    .c_req   (c_req),
    .l_req   (l_req),
    .state   (state_q),
    .lock_cnt(lock_cnt_q),
    .c_win   (c_win),
    .l_win   (l_win)
  );

  // Gating grants with reset_n drops every strobe combinationally during reset.
  assign c_gnt      = c_win & reset_n;
  assign l_gnt      = l_win & reset_n;
  assign any_gnt    = c_gnt | l_gnt;
  assign core_stall = c_req & reset_n & ~c_gnt;

  always_comb begin
    sel_we    = l_gnt ? l_we    : c_we;
    sel_addr  = l_gnt ? l_addr  : c_addr;
    sel_wdata = l_gnt ? l_wdata : c_wdata;
    sel_ok    = access_ok(AddrWMax'(sel_addr), MEM_BYTES);
  end

  assign Mem_Addr   = any_gnt ? sel_addr  : '0;
  assign Write_Data = any_gnt ? sel_wdata : '0;
  assign MemWrite   = any_gnt & sel_ok & sel_we;
  assign MemRead    = any_gnt & sel_ok & ~sel_we;
  assign rdata_d    = MemRead ? Read_Data : '0;

  always_comb begin
    state_d = StIdle;
    if (c_gnt) begin
      state_d = StCore;
    end else if (l_gnt) begin
      state_d = l_lock ? StLock : StLoad;
    end
    lock_cnt_d = lock_cnt_q;
    // Staying in lock implies a loader grant; anything else (incl. core grant) clears.
    if (state_d != StLock) begin
      lock_cnt_d = '0;
    end else if (state_q == StLock && c_req) begin
      lock_cnt_d = lock_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      lock_cnt_q <= '0;
      c_rvalid_q <= 1'b0;
      c_err_q    <= 1'b0;
      c_rdata_q  <= '0;
      l_rvalid_q <= 1'b0;
      l_err_q    <= 1'b0;
      l_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      c_rvalid_q <= c_gnt;
      c_err_q    <= c_gnt & ~sel_ok;
      c_rdata_q  <= c_gnt ? rdata_d : '0;
      l_rvalid_q <= l_gnt;
      l_err_q    <= l_gnt & ~sel_ok;
      l_rdata_q  <= l_gnt ? rdata_d : '0;
    end
  end

  assign c_rvalid = c_rvalid_q;
  assign c_err    = c_err_q;
  assign c_rdata  = c_rdata_q;
  assign l_rvalid = l_rvalid_q;
  assign l_err    = l_err_q;
  assign l_rdata  = l_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized traffic checked
// every cycle against a transaction-level arbitration and memory model.
module tb_dmem_arbiter;

  localparam int unsigned LMAX = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        c_req, c_we, l_req, l_we, l_lock;
  logic [63:0] c_addr, c_wdata, l_addr, l_wdata;
  logic        c_gnt, c_rvalid, c_err, l_gnt, l_rvalid, l_err, core_stall;
  logic [63:0] c_rdata, l_rdata, Mem_Addr, Write_Data, Read_Data;
  logic        MemWrite, MemRead;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .ADDR_W   (64),
    .DATA_W   (64),
    .MEM_BYTES(64),
    .LOCK_MAX (LMAX)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .c_req     (c_req),
    .c_we      (c_we),
    .c_addr    (c_addr),
    .c_wdata   (c_wdata),
    .c_gnt     (c_gnt),
    .c_rvalid  (c_rvalid),
    .c_rdata   (c_rdata),
    .c_err     (c_err),
    .l_req     (l_req),
    .l_we      (l_we),
    .l_addr    (l_addr),
    .l_wdata   (l_wdata),
    .l_lock    (l_lock),
    .l_gnt     (l_gnt),
    .l_rvalid  (l_rvalid),
    .l_rdata   (l_rdata),
    .l_err     (l_err),
    .core_stall(core_stall),
    .Mem_Addr  (Mem_Addr),
    .Write_Data(Write_Data),
    .MemWrite  (MemWrite),
    .MemRead   (MemRead),
    .Read_Data (Read_Data)
  );

  // Data memory: byte i holds i at start, writes land on the falling edge.
  logic [63:0] mem [8];
  bit          mem_init = 1'b0;
  assign Read_Data = (Mem_Addr < 64'd64) ? mem[Mem_Addr[5:3]] : 64'd0;

  always @(negedge clk) begin
    if (!mem_init) begin
      for (int k = 0; k < 8; k++)
        for (int b = 0; b < 8; b++) mem[k][8*b +: 8] <= 8'(8 * k + b);
      mem_init <= 1'b1;
    end else if (MemWrite && Mem_Addr < 64'd64) begin
      mem[Mem_Addr[5:3]] <= Write_Data;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: who was served last, whether the loader holds a lock and how
  // many locked grants the core has sat through, plus a shadow memory.
  bit          m_last_core = 1'b0, m_locked = 1'b0, m_c_won = 1'b0, m_l_won = 1'b0;
  int          m_streak = 0;
  bit          p_cv = 1'b0, p_ce = 1'b0, p_lv = 1'b0, p_le = 1'b0;
  logic [63:0] p_cd = '0, p_ld = '0;
  logic [63:0] ref_mem [8];
  bit          ref_init = 1'b0;

  always @(negedge clk) begin : cmp_proc
    bit          cw, lw, ok, we;
    logic [63:0] a, wd, rd;
    if (!ref_init) begin
      for (int k = 0; k < 8; k++)
        for (int b = 0; b < 8; b++) ref_mem[k][8*b +: 8] = 8'(8 * k + b);
      ref_init = 1'b1;
    end
    if (!reset_n) begin
      chk("rst_c_gnt", c_gnt, 0);
      chk("rst_l_gnt", l_gnt, 0);
      chk("rst_stall", core_stall, 0);
      chk("rst_memwrite", MemWrite, 0);
      chk("rst_memread", MemRead, 0);
      chk("rst_mem_addr", Mem_Addr, 0);
      chk("rst_c_rvalid", c_rvalid, 0);
      chk("rst_l_rvalid", l_rvalid, 0);
      chk("rst_c_err", c_err, 0);
      chk("rst_l_err", l_err, 0);
      chk("rst_c_rdata", c_rdata, 0);
      chk("rst_l_rdata", l_rdata, 0);
      m_last_core = 0; m_locked = 0; m_streak = 0; m_c_won = 0; m_l_won = 0;
      p_cv = 0; p_ce = 0; p_lv = 0; p_le = 0; p_cd = '0; p_ld = '0;
    end else begin
      chk("c_rvalid", c_rvalid, p_cv);
      chk("c_err", c_err, p_ce);
      chk("c_rdata", c_rdata, p_cd);
      chk("l_rvalid", l_rvalid, p_lv);
      chk("l_err", l_err, p_le);
      chk("l_rdata", l_rdata, p_ld);

      cw = 0; lw = 0;
      if (c_req && l_req) begin
        if (m_locked && m_streak < LMAX) lw = 1;
        else if (m_last_core)            lw = 1;
        else                             cw = 1;
      end else begin
        cw = c_req; lw = l_req;
      end
      chk("c_gnt", c_gnt, cw);
      chk("l_gnt", l_gnt, lw);
      chk("core_stall", core_stall, c_req && !cw);

      a  = lw ? l_addr  : c_addr;
      wd = lw ? l_wdata : c_wdata;
      we = lw ? l_we    : c_we;
      ok = (a % 8 == 0) && (a <= 64'd56);
      if (cw || lw) begin
        chk("memwrite", MemWrite, ok && we);
        chk("memread", MemRead, ok && !we);
        if (ok) chk("mem_addr", Mem_Addr, a);
        if (ok && we) chk("write_data", Write_Data, wd);
      end else begin
        chk("idle_mem_addr", Mem_Addr, 0);
        chk("idle_write_data", Write_Data, 0);
        chk("idle_memwrite", MemWrite, 0);
        chk("idle_memread", MemRead, 0);
      end

      rd   = (ok && !we) ? ref_mem[a[5:3]] : 64'd0;
      p_cv = cw; p_lv = lw;
      p_ce = cw && !ok; p_le = lw && !ok;
      p_cd = cw ? rd : 64'd0;
      p_ld = lw ? rd : 64'd0;
      if ((cw || lw) && ok && we) ref_mem[a[5:3]] = wd;

      if (cw) begin
        m_last_core = 1; m_locked = 0; m_streak = 0;
      end else if (lw) begin
        if (m_locked && c_req) m_streak++;
        m_last_core = 0;
        m_locked    = l_lock;
        if (!l_lock) m_streak = 0;
      end else begin
        m_last_core = 0; m_locked = 0; m_streak = 0;
      end
      m_c_won = cw; m_l_won = lw;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_c(input bit r, input bit we, input logic [63:0] a, input logic [63:0] wd);
    c_req = r; c_we = we; c_addr = a; c_wdata = wd;
  endtask

  task automatic drive_l(input bit r, input bit we, input logic [63:0] a, input logic [63:0] wd,
                         input bit lk);
    l_req = r; l_we = we; l_addr = a; l_wdata = wd; l_lock = lk;
  endtask

  function automatic logic [63:0] rand_addr();
    logic [63:0] a;
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r < 7)       a = {58'd0, 3'($urandom_range(0, 7)), 3'b000};
    else if (r == 7) a = {58'd0, 3'($urandom_range(0, 7)), 3'($urandom_range(1, 7))};
    else if (r == 8) a = 64'h40 + {58'd0, 3'($urandom_range(0, 7)), 3'b000};
    else             a = 64'hFFFF_FFFF_FFFF_FFF8;
    return a;
  endfunction

  initial begin
    logic [63:0] bad_addr [4];
    int          waits, gnt_cycle;
    bit          core_done;
    bit          exp_c [4];

    reset_n = 1'b0;
    drive_c(0, 0, 0, 0);
    drive_l(0, 0, 0, 0, 0);
    tick();
    drive_c(1, 0, 64'h0, 0);
    #1;
    chk("reset_gnt", c_gnt, 0);
    chk("reset_stall", core_stall, 0);
    chk("reset_memread", MemRead, 0);
    tick();
    reset_n = 1'b1;
    drive_c(0, 0, 0, 0);
    tick();

    // Lone core read of 0x10.
    drive_c(1, 0, 64'h10, 0);
    #1;
    chk("t1_gnt", c_gnt, 1);
    chk("t1_memread", MemRead, 1);
    chk("t1_addr", Mem_Addr, 64'h10);
    tick();
    drive_c(0, 0, 0, 0);
    chk("t1_rvalid", c_rvalid, 1);
    chk("t1_rdata", c_rdata, 64'h17161514_13121110);
    tick();
    chk("t1_rvalid_pulse", c_rvalid, 0);

    // Both requesting, no lock: strict alternation starting with the core.
    exp_c = '{1, 0, 1, 0};
    for (int i = 0; i < 4; i++) begin
      drive_c(1, 0, 64'h0, 0);
      drive_l(1, 0, 64'h8, 0, 0);
      #1;
      chk("t2_c_gnt", c_gnt, exp_c[i]);
      chk("t2_l_gnt", l_gnt, !exp_c[i]);
      chk("t2_stall", core_stall, !exp_c[i]);
      tick();
    end
    drive_c(0, 0, 0, 0);
    drive_l(0, 0, 0, 0, 0);
    tick();

    // Locked loader writes while the core waits to read the same doubleword.
    waits = 0; gnt_cycle = -1; core_done = 0;
    for (int i = 0; i < 12; i++) begin
      if (core_done && i == gnt_cycle + 1) begin
        chk("t3_rvalid", c_rvalid, 1);
        chk("t3_rdata", c_rdata, 64'hDEADBEEF_CAFEF00D);
      end
      drive_l(1, 1, 64'h8, 64'hDEADBEEF_CAFEF00D, 1);
      drive_c((i >= 1) && !core_done, 0, 64'h8, 0);
      #1;
      if (core_done && i == gnt_cycle + 1) chk("t3_loader_resumes", l_gnt, 1);
      if (c_req && l_gnt) waits++;
      if (c_gnt) begin
        core_done = 1;
        gnt_cycle = i;
      end
      tick();
    end
    chk("t3_waits", 64'(waits), 64'd8);
    chk("t3_core_cycle", 64'(gnt_cycle), 64'd9);
    drive_c(0, 0, 0, 0);
    drive_l(0, 0, 0, 0, 0);
    tick();

    // Misaligned, out-of-range and wrapping accesses, back to back.
    bad_addr = '{64'h0C, 64'h3C, 64'h40, 64'hFFFF_FFFF_FFFF_FFF8};
    for (int k = 0; k < 4; k++) begin
      drive_c(1, k[0], bad_addr[k], 64'h55);
      #1;
      chk("t4_gnt", c_gnt, 1);
      chk("t4_memread", MemRead, 0);
      chk("t4_memwrite", MemWrite, 0);
      tick();
      chk("t4_rvalid", c_rvalid, 1);
      chk("t4_err", c_err, 1);
      chk("t4_rdata", c_rdata, 0);
    end
    drive_c(0, 0, 0, 0);
    tick();

    // Reset lands in the cycle a read is granted.
    drive_c(1, 0, 64'h18, 0);
    #1;
    chk("t5_memread_before", MemRead, 1);
    reset_n = 1'b0;
    #1;
    chk("t5_memread_drop", MemRead, 0);
    chk("t5_gnt_drop", c_gnt, 0);
    tick();
    chk("t5_rvalid_in_reset", c_rvalid, 0);
    tick();
    reset_n = 1'b1;
    drive_c(0, 0, 0, 0);
    tick();
    chk("t5_no_rvalid", c_rvalid, 0);
    drive_c(1, 0, 64'h0, 0);
    drive_l(1, 0, 64'h8, 0, 0);
    #1;
    chk("t5_core_first", c_gnt, 1);
    chk("t5_loader_waits", l_gnt, 0);
    tick();
    drive_c(0, 0, 0, 0);
    drive_l(0, 0, 0, 0, 0);
    tick();

    // Random traffic; an ungranted request is held unchanged.
    for (int n = 0; n < 3000; n++) begin
      if (!c_req || m_c_won)
        drive_c($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, rand_addr(),
                {$urandom(), $urandom()});
      if (!l_req || m_l_won)
        drive_l($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, rand_addr(),
                {$urandom(), $urandom()}, $urandom_range(0, 3) != 0);
      else
        l_lock = $urandom_range(0, 3) != 0;
      tick();
    end
    drive_c(0, 0, 0, 0);
    drive_l(0, 0, 0, 0, 0);
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer that shares the single byte-addressed 64-bit data memory between the pipeline MEM stage (core port) and the test/array loader (loader port). It sits between both requesters and the data memory, issues at most one aligned doubleword access per cycle, and returns registered read data with a one-cycle latency. It also enforces bounds and alignment and bounds loader burst locking, so the core is never starved.

## Interface
- ADDR_W, 64, address width of both requesters and memory
- DATA_W, 64, data width (doubleword)
- MEM_BYTES, 64, memory size in bytes; valid access iff addr[2:0]==0 and addr+8 <= MEM_BYTES
- LOCK_MAX, 8, max consecutive loader grants under lock while core waits

Ports:
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- c_req  in  1  core request; held until granted
- c_we  in  1  core write (1) / read (0)
- c_addr  in  ADDR_W  core byte address
- c_wdata  in  DATA_W  core write data
- c_gnt  out  1  core request accepted this cycle (combinational)
- c_rvalid  out  1  one-cycle pulse: core response valid
- c_rdata  out  DATA_W  core read data, valid with c_rvalid
- c_err  out  1  with c_rvalid: access rejected
- l_req, l_we, l_addr, l_wdata, l_gnt, l_rvalid, l_rdata, l_err  same as core set, loader side
- l_lock  in  1  loader requests to keep ownership next cycle
- core_stall  out  1  c_req & ~c_gnt; freezes the pipeline
- Mem_Addr  out  ADDR_W  memory address
- Write_Data  out  DATA_W  memory write data
- MemWrite  out  1  memory write strobe
- MemRead  out  1  memory read enable
- Read_Data  in  DATA_W  combinational memory read data

## Operation
- FSM state = previous-cycle owner: S_IDLE, S_CORE, S_LOAD, S_LOCK.
- Grant rules (combinational, one winner max):
  - Only one requester: it wins.
  - Both requesting, state S_LOCK and lock_cnt < LOCK_MAX: loader wins.
  - Both requesting, otherwise: round-robin; winner is the port not granted last (S_IDLE counts as last = loader, so core wins).
- Transitions: core wins -> S_CORE; loader wins with l_lock=1 -> S_LOCK; loader wins with l_lock=0 -> S_LOAD; no request -> S_IDLE.
- lock_cnt (4 bits):
  - Increments on each loader grant in S_LOCK while c_req=1.
  - Clears on any core grant or on leaving S_LOCK.
  - At LOCK_MAX with core waiting, the core gets the next grant.
- Granted valid access: Mem_Addr/Write_Data are driven from the winner. MemWrite=we and MemRead=~we in the same cycle. The write commits at the memory's falling edge within that cycle.
- Granted invalid access (misaligned or out of range): MemWrite=MemRead=0, and the err response is returned.
- No grant: Mem_Addr=0, Write_Data=0, MemWrite=MemRead=0.
- Response register at the rising edge that ends a grant cycle:
  - rvalid=1 for the granted port, for every grant including writes.
  - rdata = Read_Data for a valid read, 0 otherwise.
  - err as computed.
- Response outputs of the non-granted port are 0.

## Timing
- Grant: same cycle as request, combinational from req and state. No request-to-gnt registering.
- Read latency 1: request granted in cycle N gives rvalid/rdata in cycle N+1 for exactly one cycle.
- Back-to-back grants to the same port are allowed every cycle. Responses pipeline one per cycle.
- Simultaneous requests: the loser holds its request and is served next cycle, except under lock, where it waits at most LOCK_MAX cycles.
- Reset:
  - state=S_IDLE, lock_cnt=0.
  - All rvalid/err/rdata = 0, all gnt=0, core_stall=0.
  - Memory strobes forced 0 combinationally while reset_n=0.
  - A response pending at reset assertion is discarded.
- Address arithmetic is full ADDR_W. An addr+8 overflow counts as out of range.

## Structure
- Shared package dmem_pkg: FSM state enum, MEM_BYTES/LOCK_MAX defaults, an access-valid function (alignment plus bounds).
- Natural sub-module: dmem_rr_pick, the two-way round-robin/lock grant picker (combinational). FSM, counter, muxes and response registers stay in dmem_arbiter.

## Test plan
- Core read addr 0x10 alone, memory holding byte i at address i -> c_gnt cycle N; c_rvalid cycle N+1 with c_rdata=0x17161514_13121110.
- Both request every cycle, no lock, 4 cycles -> grants alternate core, loader, core, loader; core_stall high on loader cycles only.
- Loader write 0xDEADBEEF_CAFEF00D to 0x08 with l_lock=1 for 12 cycles, core requesting -> 8 loader grants, then 1 core grant, then the loader resumes; core read of 0x08 returns the written value.
- Core access addr 0x0C (misaligned), then 0x3C (out of range) -> gnt asserted, MemRead=MemWrite=0, c_rvalid with c_err=1 and c_rdata=0 each.
- Assert reset_n=0 in the cycle a read is granted -> MemRead drops immediately; no rvalid after release; state S_IDLE, and core wins the first contended cycle.
